// File: rtl/ac_pattern_driver.sv
// Drives a bank of ac_flip_flop cells so their Q outputs follow a queued stream of target patterns.
// It keeps a shadow copy of the driven Q values so each excitation is chosen against the Q the cell will actually hold.
module ac_pattern_driver #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [N-1:0]               in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N-1:0]               A,
  output logic [N-1:0]               C,
  output logic [N-1:0]               q_model,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {INIT, IDLE, RUN} state_t;

  state_t         state, state_next;
  logic [N-1:0]   mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic           push, pop;
  logic [N-1:0]   head, q_pred, exc_a, exc_c, a_next, c_next;
  logic           underrun_next;

  assign in_ready = (state != INIT) && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (state == RUN);
  assign head     = mem[rd_ptr];

  // Q each driven cell takes at the coming edge: q_pred = f(q_model, A, C).
  always_comb begin
    q_pred = q_model;
    for (int i = 0; i < N; i++) begin
      case ({A[i], C[i]})
        2'b01:   q_pred[i] = ~q_model[i];
        2'b10:   q_pred[i] = q_model[i];
        default: q_pred[i] = 1'b1;
      endcase
    end
  end

  // Target 1 sets the cell; target 0 toggles a 1 down or holds an existing 0.
  assign exc_a = ~head & ~q_pred;
  assign exc_c = ~head &  q_pred;

  always_comb begin
    state_next    = state;
    a_next        = '1;
    c_next        = '0;
    pop           = 1'b0;
    underrun_next = 1'b0;
    case (state)
      INIT: state_next = IDLE;
      IDLE: begin
        if (start && !stop) state_next = RUN;
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (count != '0) begin
          pop    = 1'b1;
          a_next = exc_a;
          c_next = exc_c;
        end else begin
          underrun_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      A        <= '0;
      C        <= '0;
      q_model  <= '1;
      underrun <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_next;
      A        <= a_next;
      C        <= c_next;
      q_model  <= q_pred;
      underrun <= underrun_next;
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_ac_pattern_driver.sv
// Directed bench for ac_pattern_driver: a queue-based model checks every cycle,
// and hand-computed literals pin key points of each scenario.
module tb_ac_pattern_driver;

  logic       clk = 1'b0;
  logic       rst, start, stop, in_valid;
  logic [3:0] in_data;
  logic       in_ready, busy, underrun;
  logic [3:0] A, C, q_model;
  logic [2:0] count;

  int checks = 0;
  int fails  = 0;

  ac_pattern_driver #(.N(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .C(C), .q_model(q_model), .count(count),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cell law from the truth table: 00->1, 01->~q, 11->1, 10->q.
  function automatic logic [3:0] cell_law(input logic [3:0] q, input logic [3:0] a, input logic [3:0] c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      if (a[i] == 1'b0 && c[i] == 1'b1)      r[i] = ~q[i];
      else if (a[i] == 1'b1 && c[i] == 1'b0) r[i] = q[i];
      else                                   r[i] = 1'b1;
    end
    return r;
  endfunction

  // Behavioural model: pattern queue, run flag, expected pins and a physical bank fed by the DUT pins.
  logic [3:0] fifo[$];
  bit         m_init, m_run, m_und;
  logic [3:0] m_a, m_c, m_q, bank_q;

  always @(posedge clk) begin
    logic [3:0] nq, t;
    bit         ready;
    if (rst) begin
      m_init = 1; m_run = 0; m_und = 0;
      m_a = 4'h0; m_c = 4'h0; m_q = 4'hF;
      fifo.delete();
      bank_q = 4'hF;
    end else begin
      bank_q = cell_law(bank_q, A, C);
      ready  = !m_init && fifo.size() < 4;
      nq     = cell_law(m_q, m_a, m_c);
      m_und  = 0;
      m_a    = 4'hF;
      m_c    = 4'h0;
      if (m_init) begin
        m_init = 0;
      end else if (!m_run) begin
        if (start && !stop) m_run = 1;
      end else if (stop) begin
        m_run = 0;
      end else if (fifo.size() > 0) begin
        t = fifo.pop_front();
        for (int i = 0; i < 4; i++) begin
          if (t[i])       begin m_a[i] = 1'b0; m_c[i] = 1'b0; end
          else if (nq[i]) begin m_a[i] = 1'b0; m_c[i] = 1'b1; end
          else            begin m_a[i] = 1'b1; m_c[i] = 1'b0; end
        end
      end else begin
        m_und = 1;
        m_run = 0;
      end
      if (in_valid && ready) fifo.push_back(in_data);
      m_q = nq;
    end
    #1;
    checkOutput("model A",        32'(A),        32'(m_a));
    checkOutput("model C",        32'(C),        32'(m_c));
    checkOutput("model q_model",  32'(q_model),  32'(m_q));
    checkOutput("bank Q",         32'(q_model),  32'(bank_q));
    checkOutput("model count",    32'(count),    32'(fifo.size()));
    checkOutput("model busy",     32'(busy),     32'(m_run));
    checkOutput("model underrun", 32'(underrun), 32'(m_und));
    checkOutput("model in_ready", 32'(in_ready), 32'(!m_init && fifo.size() < 4));
  end

  task automatic applyStimulus(input logic st, input logic sp, input logic r);
    start = st;
    stop  = sp;
    rst   = r;
    @(negedge clk);
  endtask

  // Present a pattern and hold it until the driver accepts it (bounded).
  task automatic pushPattern(input logic [3:0] d);
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 20; n++) begin
      ok = in_ready;
      @(negedge clk);
      if (ok) return;
    end
    checkOutput("push timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    start = 0; stop = 0; in_valid = 0; in_data = 4'h0; rst = 1;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    checkOutput("reset A", 32'(A), 32'h0);
    checkOutput("reset C", 32'(C), 32'h0);
    checkOutput("reset q", 32'(q_model), 32'hF);
    checkOutput("reset in_ready", 32'(in_ready), 32'h0);
    applyStimulus(0, 0, 0);
    checkOutput("idle A", 32'(A), 32'hF);
    checkOutput("idle C", 32'(C), 32'h0);
    checkOutput("idle in_ready", 32'(in_ready), 32'h1);

    // Three patterns played back to back, then underrun.
    pushPattern(4'b0000);
    pushPattern(4'b1010);
    pushPattern(4'b0101);
    in_valid = 0;
    checkOutput("queued count", 32'(count), 32'h3);
    applyStimulus(1, 0, 0);
    checkOutput("run busy", 32'(busy), 32'h1);
    applyStimulus(0, 0, 0);
    checkOutput("pop0 A", 32'(A), 32'b0000);
    checkOutput("pop0 C", 32'(C), 32'b1111);
    applyStimulus(0, 0, 0);
    checkOutput("pop1 A", 32'(A), 32'b0101);
    checkOutput("pop1 C", 32'(C), 32'b0000);
    checkOutput("pop1 q", 32'(q_model), 32'b0000);
    applyStimulus(0, 0, 0);
    checkOutput("pop2 A", 32'(A), 32'b0000);
    checkOutput("pop2 C", 32'(C), 32'b1010);
    checkOutput("pop2 q", 32'(q_model), 32'b1010);
    applyStimulus(0, 0, 0);
    checkOutput("underrun pulse", 32'(underrun), 32'h1);
    checkOutput("underrun busy", 32'(busy), 32'h0);
    checkOutput("after q", 32'(q_model), 32'b0101);
    applyStimulus(0, 0, 0);
    checkOutput("underrun clears", 32'(underrun), 32'h0);

    // Single pattern then empty FIFO.
    pushPattern(4'b0110);
    in_valid = 0;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("single A", 32'(A), 32'b1000);
    checkOutput("single C", 32'(C), 32'b0001);
    applyStimulus(0, 0, 0);
    checkOutput("single underrun", 32'(underrun), 32'h1);
    checkOutput("single q", 32'(q_model), 32'b0110);
    checkOutput("single hold A", 32'(A), 32'hF);

    // Fill, stall on full, then stream through with wrapping pointers.
    pushPattern(4'h1);
    pushPattern(4'h2);
    pushPattern(4'h3);
    pushPattern(4'h4);
    in_data = 4'h5;
    checkOutput("full count", 32'(count), 32'h4);
    checkOutput("full in_ready", 32'(in_ready), 32'h0);
    applyStimulus(1, 0, 0);
    checkOutput("full stall count", 32'(count), 32'h4);
    start = 0;
    for (int k = 5; k < 13; k++) pushPattern(4'(k));
    in_valid = 0;
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    checkOutput("drain done", 32'(busy), 32'h0);

    // start+stop together, then stop after one pop.
    applyStimulus(1, 1, 0);
    checkOutput("start+stop busy", 32'(busy), 32'h0);
    start = 0; stop = 0;
    pushPattern(4'h9);
    pushPattern(4'hA);
    pushPattern(4'hB);
    in_valid = 0;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("stop busy", 32'(busy), 32'h0);
    checkOutput("stop count", 32'(count), 32'h2);
    checkOutput("stop A", 32'(A), 32'hF);
    checkOutput("stop C", 32'(C), 32'h0);

    // Reset in the middle of a run.
    stop = 0;
    pushPattern(4'hC);
    in_valid = 0;
    applyStimulus(1, 0, 0);
    checkOutput("mid count", 32'(count), 32'h3);
    applyStimulus(0, 0, 1);
    checkOutput("rst count", 32'(count), 32'h0);
    checkOutput("rst q", 32'(q_model), 32'hF);
    checkOutput("rst A", 32'(A), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    applyStimulus(0, 0, 0);
    checkOutput("rst idle A", 32'(A), 32'hF);
    checkOutput("rst idle ready", 32'(in_ready), 32'h1);
    applyStimulus(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
